// File: rtl/exe_divider_if.sv
// Handshake bundle between the execute stage and the multi-cycle divider.
// The pipeline side drives requests/operands, the divider returns result and stall.
interface exe_divider_if;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        div_ready;
  logic [63:0] div_result;
  logic        stall_req;

  modport master (
    output div_start, div_signed, dividend, divisor, flush,
    input  div_ready, div_result, stall_req
  );

  modport slave (
    input  div_start, div_signed, dividend, divisor, flush,
    output div_ready, div_result, stall_req
  );
endinterface

// File: rtl/exe_divider.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU; result is {remainder, quotient}.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |divisor| > |dividend|.
module exe_divider (
  input  logic          clk,
  input  logic          rst,
  exe_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [5:0]  count_reg, count_next;
  logic [64:0] work_reg, work_next;
  logic [31:0] divisor_reg, divisor_next;
  logic        q_neg_reg, q_neg_next;
  logic        r_neg_reg, r_neg_next;
  logic [63:0] result_reg, result_next;

  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;
  logic        early_out;
  logic [33:0] trial;
  logic [64:0] iter;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Magnitudes as unsigned 32-bit values, so |0x80000000| is representable.
  assign dividend_mag = (bus.div_signed && bus.dividend[31]) ? -bus.dividend : bus.dividend;
  assign divisor_mag  = (bus.div_signed && bus.divisor[31])  ? -bus.divisor  : bus.divisor;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (divisor_mag > dividend_mag);
`else
  assign early_out = 1'b0;
`endif

  // work_reg[64:31] is the partial remainder already shifted left by one.
  assign trial = work_reg[64:31] - {2'b00, divisor_reg};
  assign iter  = trial[33] ? {work_reg[63:0], 1'b0}
                           : {trial[32:0], work_reg[30:0], 1'b1};

  assign quo_fix = q_neg_reg ? -iter[31:0]  : iter[31:0];
  assign rem_fix = r_neg_reg ? -iter[63:32] : iter[63:32];

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    work_next    = work_reg;
    divisor_next = divisor_reg;
    q_neg_next   = q_neg_reg;
    r_neg_next   = r_neg_reg;
    result_next  = result_reg;

    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.div_start) begin
            if (bus.divisor == 32'h0) begin
              state_next  = DONE;
              result_next = 64'h0;
            end else if (early_out) begin
              state_next  = DONE;
              result_next = {bus.dividend, 32'h0};
            end else begin
              state_next   = BUSY;
              count_next   = 6'd0;
              work_next    = {33'h0, dividend_mag};
              divisor_next = divisor_mag;
              q_neg_next   = bus.div_signed & (bus.dividend[31] ^ bus.divisor[31]);
              r_neg_next   = bus.div_signed & bus.dividend[31];
            end
          end
        end
        BUSY: begin
          work_next  = iter;
          count_next = count_reg + 6'd1;
          if (count_reg == 6'd31) begin
            state_next  = DONE;
            result_next = {rem_fix, quo_fix};
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= 6'd0;
      work_reg    <= 65'h0;
      divisor_reg <= 32'h0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      result_reg  <= 64'h0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      work_reg    <= work_next;
      divisor_reg <= divisor_next;
      q_neg_reg   <= q_neg_next;
      r_neg_reg   <= r_neg_next;
      result_reg  <= result_next;
    end
  end

  assign bus.div_ready  = (state_reg == DONE);
  assign bus.div_result = result_reg;
  assign bus.stall_req  = bus.div_start & ~bus.div_ready;

endmodule

// File: tb/tb_exe_divider.sv
// Randomized + directed bench for exe_divider against an arithmetic reference model.
module tb_exe_divider;

  localparam bit EARLY_EN =
`ifdef DIV_EARLY_OUT_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_divider_if bus();

  exe_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state: transaction-level view of the divider.
  bit          m_busy = 1'b0;
  int          m_done = -1;
  logic [63:0] m_res  = 64'h0;
  logic [63:0] m_pend = 64'h0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint ma, mb;
    if (b == 32'h0) return 1;
    ma = s ? longint'($signed(a)) : longint'({32'h0, a});
    mb = s ? longint'($signed(b)) : longint'({32'h0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (EARLY_EN && mb > ma) return 1;
    return 33;
  endfunction

  // Model advance on every rising edge (inputs are stable here).
  always @(posedge clk) begin
    int lat;
    if (rst) begin
      m_busy = 1'b0;
      m_done = -1;
      m_res  = 64'h0;
    end else if (bus.flush) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (cyc == m_done - 1) m_res = m_pend;
      if (cyc == m_done) m_busy = 1'b0;
    end else if (bus.div_start) begin
      m_pend = ref_div(bus.dividend, bus.divisor, bus.div_signed);
      lat    = ref_lat(bus.dividend, bus.divisor, bus.div_signed);
      m_done = cyc + lat;
      m_busy = 1'b1;
      if (lat == 1) m_res = m_pend;
    end
    cyc++;
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    logic exp_rdy;
    if (rst) begin
      check("rst_ready", {63'h0, bus.div_ready}, 64'h0);
      check("rst_result", bus.div_result, 64'h0);
    end else begin
      exp_rdy = m_busy && (cyc == m_done);
      check("ready", {63'h0, bus.div_ready}, {63'h0, exp_rdy});
      check("result", bus.div_result, m_res);
      check("stall_req", {63'h0, bus.stall_req}, {63'h0, bus.div_start & ~exp_rdy});
    end
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int exp_lat, input logic [63:0] exp_res, input string nm);
    int n;
    @(posedge clk); #1;
    bus.div_start  = 1'b1;
    bus.div_signed = s;
    bus.dividend   = a;
    bus.divisor    = b;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.div_ready) break;
      n++;
      if (n > 100) begin
        check({nm, "_timeout"}, 64'(n), 64'(exp_lat));
        break;
      end
    end
    check({nm, "_latency"}, 64'(n), 64'(exp_lat));
    check({nm, "_result"}, bus.div_result, exp_res);
    $display("dir %-12s a=%h b=%h s=%0d lat=%0d res=%h", nm, a, b, s, n, bus.div_result);
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    bus.div_start = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom % 16);
      4: return 32'($urandom);
      default: return 32'($urandom) >> ($urandom % 31);
    endcase
  endfunction

  initial begin
    int rdy_cnt, fa, k;
    bit flushed;
    logic [31:0] a, b;
    logic s;

    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = 32'h0;
    bus.divisor    = 32'h0;
    bus.flush      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Pin the reference model with hand-computed values.
    check("model_divu_100_7", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    check("model_div_m7_2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    check("model_div_7_m2", ref_div(32'd7, 32'hFFFF_FFFE, 1'b1), {32'h0000_0001, 32'hFFFF_FFFD});
    check("model_div_min_m1", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'h0, 32'h8000_0000});

    run_div(32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, "divu_100_7");
    go_idle(2);
    run_div(32'h1234, 32'h0, 1'b0, 1, 64'h0, "divu_by_0");
    go_idle(2);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
    go_idle(1);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 33, {32'h0000_0001, 32'hFFFF_FFFD}, "div_7_m2");
    go_idle(2);

    // Flush in cycle 10 of DIVU 1000/3: no ready, previous result held.
    @(posedge clk); #1;
    bus.div_start = 1'b1; bus.div_signed = 1'b0;
    bus.dividend = 32'd1000; bus.divisor = 32'd3;
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.div_start = 1'b0;
    rdy_cnt = 0;
    repeat (36) begin
      @(negedge clk);
      if (bus.div_ready) rdy_cnt++;
    end
    check("flush_no_ready", 64'(rdy_cnt), 64'h0);
    check("flush_result_kept", bus.div_result, {32'h0000_0001, 32'hFFFF_FFFD});
    $display("dir flush_1000_3 ready_count=%0d res=%h", rdy_cnt, bus.div_result);
    run_div(32'd9, 32'd3, 1'b0, 33, {32'd0, 32'd3}, "divu_9_3");
    go_idle(2);

    // Back-to-back pair, then reset in cycle 20 of a third divide.
    run_div(32'd50, 32'd5, 1'b0, 33, {32'd0, 32'd10}, "divu_50_5");
    run_div(32'd81, 32'd9, 1'b0, 33, {32'd0, 32'd9}, "divu_81_9");
    @(posedge clk); #1;
    bus.dividend = 32'd1000; bus.divisor = 32'd7;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_result", bus.div_result, 64'h0);
    check("rst_mid_ready", {63'h0, bus.div_ready}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0; bus.div_start = 1'b0;
    rdy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.div_ready) rdy_cnt++;
    end
    check("rst_no_ready", 64'(rdy_cnt), 64'h0);
    $display("dir rst_mid ready_count=%0d res=%h", rdy_cnt, bus.div_result);

    run_div(32'd5, 32'd9, 1'b0, EARLY_EN ? 1 : 33, {32'd5, 32'd0}, "divu_5_9");
    go_idle(1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, {32'h0, 32'h8000_0000}, "div_min_m1");
    go_idle(2);

    // Randomized transactions with occasional flushes and idle gaps.
    for (int i = 0; i < 60; i++) begin
      a = rnd32(); b = rnd32(); s = 1'($urandom % 2);
      fa = ($urandom % 6 == 0) ? int'($urandom % 36) : -1;
      @(posedge clk); #1;
      bus.div_start = 1'b1; bus.div_signed = s;
      bus.dividend = a; bus.divisor = b;
      bus.flush = (fa == 0);
      k = 0; flushed = 1'b0;
      while (1) begin
        @(negedge clk);
        if (bus.flush) begin flushed = 1'b1; break; end
        if (bus.div_ready) break;
        k++;
        if (k > 100) begin
          check("rand_timeout", 64'(k), 64'd33);
          break;
        end
        @(posedge clk); #1;
        bus.flush = (k == fa);
      end
      $display("rnd %0d a=%h b=%h s=%0d cyc=%0d flushed=%0d res=%h", i, a, b, s, k, flushed, bus.div_result);
      if (flushed || ($urandom % 3 == 0)) begin
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.div_start = 1'b0;
        repeat ($urandom % 3) @(posedge clk);
      end
    end
    go_idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/exe_divider.md
# exe_divider

Multi-cycle 32-bit integer divider for the execute stage; it serves DIV and DIVU instructions issued from the ID/EXE pipeline register. It computes quotient and remainder with a radix-2 restoring algorithm. While the result is pending it holds the pipeline through a stall request to the pipeline controller. The 64-bit result goes to the HI/LO write path: remainder → HI, quotient → LO.

## Interface
- No parameters. Width fixed at 32 bits.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- div_start  in  1  a DIV/DIVU instruction is present in the execute stage; held high while the stage is stalled.
- div_signed  in  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  in  32  execute-stage source operand 1; sampled only in IDLE.
- divisor  in  32  execute-stage source operand 2; sampled only in IDLE.
- flush  in  1  exception flush; aborts any division in progress.
- div_ready  out  1  result valid; high for exactly one cycle.
- div_result  out  64  {remainder, quotient}; held until the next division completes.
- stall_req  out  1  div_start & ~div_ready; request to the pipeline controller to stall the stages through execute.

## Operation
- States:
  - IDLE: waiting for a division.
  - BUSY: iterating, one bit per cycle.
  - DONE: result presented.
- IDLE, div_start=1, flush=0:
  - If divisor==0: go to DONE with div_result=64'h0.
  - Otherwise: latch |dividend| and |divisor|. Magnitudes are taken only when div_signed=1; otherwise operands are used raw.
  - Also latch the quotient sign (dividend[31]^divisor[31]) and the remainder sign (dividend[31]), both gated by div_signed.
  - Clear the 6-bit counter and go to BUSY.
- BUSY, each cycle:
  - Working register is 65 bits: {partial remainder 33, quotient 32}.
  - Shift left 1, then trial-subtract divisor from bits [64:32].
  - If the result is non-negative, keep it and set bit 0 = 1; otherwise restore and set bit 0 = 0.
  - Counter increments each cycle. After the 32nd iteration go to DONE.
- Entering DONE:
  - Sign correction: quotient is negated if its sign flag is set; remainder is negated if its sign flag is set.
  - div_result is written with the corrected values.
- DONE: div_ready=1. Go unconditionally to IDLE next cycle.
  - A back-to-back divide therefore begins from IDLE in the following cycle, sampling the new instruction's operands.
- flush=1 in any state: go to IDLE next edge. div_ready stays 0 and div_result is unchanged.
- Arithmetic special cases:
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0 (wrap, no trap).
  - Divide by zero raises no exception.

## Timing
- Reset values:
  - state=IDLE, counter=0, working register=0.
  - div_result=64'h0, div_ready=0.
  - stall_req follows div_start (combinational).
- Latency, with div_start first high in cycle 0:
  - Normal: BUSY in cycles 1–32, DONE/div_ready in cycle 33; stall_req high in cycles 0–32, low in 33.
  - Divide by zero: div_ready in cycle 1.
- Operand changes after cycle 0 are ignored until the next IDLE sample.
- Simultaneous flush and div_start in IDLE: flush wins, no division starts.
- rst asserted mid-division: immediate return to IDLE, outputs reset.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - In IDLE, if divisor magnitude > dividend magnitude (after sign handling), go directly to DONE.
  - Result is quotient 0, remainder = original dividend; div_ready in cycle 1.
- DIV_EARLY_OUT_EN undefined: such cases take the full 33-cycle path. Results are identical either way.

## Test plan
- DIVU 100/7, start at cycle 0 → div_ready in cycle 33, div_result={32'd2, 32'd14}; stall_req high in cycles 0–32.
- DIV 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 7/0xFFFFFFFE → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIVU 0x1234/0 → div_ready in cycle 1, div_result=64'h0.
- flush in cycle 10 of DIVU 1000/3 → IDLE in cycle 11, no div_ready, previous div_result kept; a new start of 9/3 then yields {0, 3} 33 cycles later.
- Two consecutive DIVU instructions (50/5, then 81/9) → div_ready in cycles 33 and 67 with {0,10} and {0,9}; rst pulsed at cycle 20 of a third divide → outputs 0, state IDLE.
- With DIV_EARLY_OUT_EN, DIVU 5/9 → div_ready in cycle 1, result {32'd5, 32'd0}; without the macro, the same stimulus gives ready in cycle 33.
